// File: rtl/div_rr_scheduler.sv
// div_rr_scheduler
//   Shares one iterative restoring divider (one quotient bit per cycle) among
//   NREQ requesters. Round-robin arbitration picks a requester in IDLE. Each
//   result is returned on one valid/ready response port, tagged with the id
//   of the requester that owns it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid[i]      requester i has an operation pending
//   req_ready[i]      grant/accept for requester i (one-hot or zero)
//   req_dividend      flattened operands, requester i at [i*N +: N]
//   req_divisor       flattened operands, requester i at [i*N +: N]
//   rsp_valid         result available
//   rsp_ready         consumer takes the result
//   rsp_id            owner of the result
//   rsp_quotient      quotient
//   rsp_remainder     remainder
//   rsp_div_by_zero   divisor was zero (quotient all ones, remainder = dividend)
//   busy              an operation is in flight or awaiting handshake
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | arbitrate; accept granted request and load operands
// S_CALC | one restoring-divide iteration per cycle, N cycles
// S_DONE | hold result on rsp_*, wait for rsp_ready
module div_rr_scheduler #(
  parameter int N    = 24,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_dividend,
  input  logic [NREQ*N-1:0] req_divisor,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_quotient,
  output logic [N-1:0]      rsp_remainder,
  output logic              rsp_div_by_zero,
  output logic              busy
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   dq_q, dq_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [IDW-1:0] id_q, id_d;
  logic           dbz_q, dbz_d;

  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [N-1:0]   rem_sh;
  logic [N-1:0]   sel_dividend;
  logic [N-1:0]   sel_divisor;

  // Rotating priority search starting at ptr_q.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int o = 0; o < NREQ; o++) begin
      idx = (int'(ptr_q) + o) % NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  // Gated by rst_n so no grant is advertised while reset is held.
  always_comb begin
    req_ready = '0;
    if ((state_q == S_IDLE) && gnt_any && rst_n) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign sel_dividend = req_dividend[int'(gnt_idx)*N +: N];
  assign sel_divisor  = req_divisor[int'(gnt_idx)*N +: N];

  // Remainder is kept at N bits; the shifted-out MSB is intentionally dropped.
  assign rem_sh = {rem_q[N-2:0], dq_q[N-1]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    id_d    = id_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          state_d = S_CALC;
          dq_d    = sel_dividend;
          dvs_d   = sel_divisor;
          rem_d   = '0;
          id_d    = gnt_idx;
          dbz_d   = (sel_divisor == '0);
          cnt_d   = CW'(N - 1);
          ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      S_CALC: begin
        if (rem_sh >= dvs_q) begin
          rem_d = rem_sh - dvs_q;
          dq_d  = {dq_q[N-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          dq_d  = {dq_q[N-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      id_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      id_q    <= id_d;
      dbz_q   <= dbz_d;
    end
  end

  // Result registers double as the response; they hold after the handshake
  // until the next accepted operation reloads them.
  assign rsp_valid       = (state_q == S_DONE);
  assign busy            = (state_q != S_IDLE);
  assign rsp_id          = id_q;
  assign rsp_quotient    = dq_q;
  assign rsp_remainder   = rem_q;
  assign rsp_div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_rr_scheduler.sv
module tb_div_rr_scheduler;

  localparam int N    = 24;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_dividend;
  logic [NREQ*N-1:0] req_divisor;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_quotient;
  logic [N-1:0]      rsp_remainder;
  logic              rsp_div_by_zero;
  logic              busy;

  int errors = 0;
  int checks = 0;

  // results of the most recent run_op
  logic           op_ok;
  int             op_lat;
  logic           op_rdy_after;
  logic [IDW-1:0] op_id;
  logic [N-1:0]   op_q;
  logic [N-1:0]   op_r;
  logic           op_dbz;

  div_rr_scheduler #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_dividend    (req_dividend),
    .req_divisor     (req_divisor),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_quotient    (rsp_quotient),
    .rsp_remainder   (rsp_remainder),
    .rsp_div_by_zero (rsp_div_by_zero),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference restoring divider, N-bit remainder, no width growth.
  function automatic void model_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] q, output logic [N-1:0] r);
    logic [N-1:0] rem, dq, rs;
    rem = '0;
    dq  = a;
    for (int i = 0; i < N; i++) begin
      rs = {rem[N-2:0], dq[N-1]};
      dq = dq << 1;
      if (rs >= b) begin
        rem   = rs - b;
        dq[0] = 1'b1;
      end else begin
        rem = rs;
      end
    end
    q = dq;
    r = rem;
  endfunction

  // Drives one request on port id, waits for its result, performs the response
  // handshake. Returns observations only; callers compare.
  task automatic run_op(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    int w;
    op_ok = 1'b1; op_lat = 0; op_rdy_after = 1'b0;
    op_id = '0; op_q = '0; op_r = '0; op_dbz = 1'b0;
    req_dividend[id*N +: N] = a;
    req_divisor[id*N +: N]  = b;
    req_valid[id] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[id] && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready[id]) begin
      op_ok = 1'b0;
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    op_rdy_after = req_ready[id];
    req_valid[id] = 1'b0;
    while (!rsp_valid && op_lat < 100) begin
      @(posedge clk); #1; op_lat++;
    end
    if (!rsp_valid) begin
      op_ok = 1'b0;
      return;
    end
    op_id  = rsp_id;
    op_q   = rsp_quotient;
    op_r   = rsp_remainder;
    op_dbz = rsp_div_by_zero;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; req_dividend = '0; req_divisor = '0; rsp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div_by_zero, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b v=%b id=%0d q=%0h r=%0h dbz=%b busy=%b, expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div_by_zero, busy);
    end
    req_valid = 4'hF; #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready_gated: got %b expected 0000", req_ready);
    end
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b v=%b expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_single();
    run_op(0, 24'd100, 24'd7);
    checks++;
    if (!op_ok || op_lat != N) begin
      errors++;
      $display("FAIL single_latency: got ok=%b lat=%0d expected ok=1 lat=%0d", op_ok, op_lat, N);
    end
    checks++;
    if ({op_id, op_q, op_r, op_dbz} !== {2'd0, 24'd14, 24'd2, 1'b0}) begin
      errors++;
      $display("FAIL single_result: got id=%0d q=%0d r=%0d dbz=%b expected id=0 q=14 r=2 dbz=0",
               op_id, op_q, op_r, op_dbz);
    end
    checks++;
    if (op_rdy_after !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_one_cycle: got req_ready[0]=%b after accept expected 0", op_rdy_after);
    end
    checks++;
    if ({rsp_valid, busy} !== 2'b00 || rsp_quotient !== 24'd14 || rsp_remainder !== 24'd2) begin
      errors++;
      $display("FAIL single_after_handshake: got v=%b busy=%b q=%0d r=%0d expected 0 0 14 2",
               rsp_valid, busy, rsp_quotient, rsp_remainder);
    end
  endtask

  task automatic test_div_by_zero();
    run_op(2, 24'h00ABCD, 24'd0);
    checks++;
    if (!op_ok || op_lat != N) begin
      errors++;
      $display("FAIL dbz_latency: got ok=%b lat=%0d expected ok=1 lat=%0d", op_ok, op_lat, N);
    end
    checks++;
    if ({op_id, op_q, op_r, op_dbz} !== {2'd2, 24'hFFFFFF, 24'h00ABCD, 1'b1}) begin
      errors++;
      $display("FAIL dbz_result: got id=%0d q=%0h r=%0h dbz=%b expected id=2 q=ffffff r=abcd dbz=1",
               op_id, op_q, op_r, op_dbz);
    end
  endtask

  task automatic test_edge_values();
    logic [N-1:0] va[4] = '{24'hFFFFFF, 24'd5, 24'd0, 24'hFFFFFF};
    logic [N-1:0] vb[4] = '{24'd1, 24'd9, 24'd5, 24'hFFFFFF};
    logic [N-1:0] eq[4] = '{24'hFFFFFF, 24'd0, 24'd0, 24'd1};
    logic [N-1:0] er[4] = '{24'd0, 24'd5, 24'd0, 24'd0};
    for (int k = 0; k < 4; k++) begin
      run_op(k, va[k], vb[k]);
      checks++;
      if (!op_ok || op_lat != N || {op_id, op_q, op_r, op_dbz} !== {IDW'(k), eq[k], er[k], 1'b0}) begin
        errors++;
        $display("FAIL edge_%0d: got ok=%b lat=%0d id=%0d q=%0h r=%0h dbz=%b expected lat=%0d id=%0d q=%0h r=%0h dbz=0",
                 k, op_ok, op_lat, op_id, op_q, op_r, op_dbz, N, k, eq[k], er[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    int           exp_id[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp_q[5]  = '{24'd333, 24'd250, 24'd200, 24'd167, 24'd333};
    logic [N-1:0] exp_r[5]  = '{24'd1, 24'd1, 24'd2, 24'd1, 24'd1};
    int           seen_c[5];
    logic [IDW-1:0] seen_id[5];
    logic [N-1:0] seen_q[5];
    logic [N-1:0] seen_r[5];
    int got, c;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_dividend[i*N +: N] = N'(1000 + i);
      req_divisor[i*N +: N]  = N'(3 + i);
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rr_first_grant: got %b expected 0001", req_ready);
    end
    got = 0; c = 0;
    while (got < 5 && c < 300) begin
      @(posedge clk); #1; c++;
      if (rsp_valid) begin
        seen_c[got] = c; seen_id[got] = rsp_id;
        seen_q[got] = rsp_quotient; seen_r[got] = rsp_remainder;
        got++;
      end
    end
    req_valid = '0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (got != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d responses expected 5", got);
    end else begin
      checks++;
      if (seen_c[0] != N + 1) begin
        errors++;
        $display("FAIL rr_first_latency: got cycle %0d expected %0d", seen_c[0], N + 1);
      end
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (int'(seen_id[k]) != exp_id[k] || seen_q[k] !== exp_q[k] || seen_r[k] !== exp_r[k]) begin
          errors++;
          $display("FAIL rr_resp_%0d: got id=%0d q=%0d r=%0d expected id=%0d q=%0d r=%0d",
                   k, seen_id[k], seen_q[k], seen_r[k], exp_id[k], exp_q[k], exp_r[k]);
        end
        if (k > 0) begin
          checks++;
          if (seen_c[k] - seen_c[k-1] != N + 2) begin
            errors++;
            $display("FAIL rr_spacing_%0d: got %0d expected %0d", k, seen_c[k] - seen_c[k-1], N + 2);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    int w;
    req_dividend[1*N +: N] = 24'd50; req_divisor[1*N +: N] = 24'd7;
    req_valid[1] = 1'b1; #1;
    w = 0;
    while (!req_ready[1] && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    req_dividend[3*N +: N] = 24'd77; req_divisor[3*N +: N] = 24'd10;
    req_valid[3] = 1'b1;
    w = 0;
    while (!rsp_valid && w < 100) begin @(posedge clk); #1; w++; end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL stall_rsp_timeout: got rsp_valid=0 expected 1");
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, busy, req_ready, rsp_id, rsp_quotient, rsp_remainder, rsp_div_by_zero} !==
          {1'b1, 1'b1, 4'b0000, 2'd1, 24'd7, 24'd1, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b busy=%b ready=%b id=%0d q=%0d r=%0d dbz=%b expected 1 1 0000 1 7 1 0",
                 k, rsp_valid, busy, req_ready, rsp_id, rsp_quotient, rsp_remainder, rsp_div_by_zero);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, busy, req_ready} !== {1'b0, 1'b0, 4'b1000}) begin
      errors++;
      $display("FAIL stall_release: got v=%b busy=%b ready=%b expected 0 0 1000", rsp_valid, busy, req_ready);
    end
    run_op(3, 24'd77, 24'd10);
    checks++;
    if (!op_ok || op_lat != N || {op_id, op_q, op_r} !== {2'd3, 24'd7, 24'd7}) begin
      errors++;
      $display("FAIL stall_waiter: got ok=%b lat=%0d id=%0d q=%0d r=%0d expected lat=%0d id=3 q=7 r=7",
               op_ok, op_lat, op_id, op_q, op_r, N);
    end
  endtask

  task automatic test_reset_mid_calc();
    int w;
    req_dividend[2*N +: N] = 24'h123456; req_divisor[2*N +: N] = 24'h77;
    req_valid[2] = 1'b1; #1;
    w = 0;
    while (!req_ready[2] && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    req_dividend[1*N +: N] = 24'd90; req_divisor[1*N +: N] = 24'd4;
    req_valid[1] = 1'b1;
    rst_n = 1'b0; #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div_by_zero, busy} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got ready=%b v=%b id=%0d q=%0h r=%0h dbz=%b busy=%b expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div_by_zero, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_dividend[3*N +: N] = 24'd30; req_divisor[3*N +: N] = 24'd4;
    req_valid[3] = 1'b1; #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL midreset_ptr_zero: got %b expected 0010", req_ready);
    end
    run_op(1, 24'd90, 24'd4);
    req_valid[3] = 1'b0;
    checks++;
    if (!op_ok || op_lat != N || {op_id, op_q, op_r, op_dbz} !== {2'd1, 24'd22, 24'd2, 1'b0}) begin
      errors++;
      $display("FAIL midreset_next_op: got ok=%b lat=%0d id=%0d q=%0d r=%0d dbz=%b expected lat=%0d id=1 q=22 r=2 dbz=0",
               op_ok, op_lat, op_id, op_q, op_r, op_dbz, N);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, mq, mr;
    int id, sel;
    for (int k = 0; k < 1000; k++) begin
      id  = int'($urandom_range(0, NREQ - 1));
      a   = N'($urandom);
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       b = '0;
        1:       b = N'(1);
        2:       b = N'($urandom);
        default: b = N'($urandom >> $urandom_range(8, 31));
      endcase
      model_div(a, b, mq, mr);
      run_op(id, a, b);
      checks++;
      if (!op_ok || op_lat != N || {op_id, op_q, op_r, op_dbz} !== {IDW'(id), mq, mr, (b == '0)}) begin
        errors++;
        $display("FAIL random_%0d: %0h/%0h got ok=%b lat=%0d id=%0d q=%0h r=%0h dbz=%b expected id=%0d q=%0h r=%0h dbz=%b",
                 k, a, b, op_ok, op_lat, op_id, op_q, op_r, op_dbz, id, mq, mr, (b == '0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_div_by_zero();
    test_edge_values();
    test_round_robin();
    test_stall();
    test_reset_mid_calc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
